seg_frame_decoder: RTL and testbench

SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

---
 rtl/seg_frame_decoder.sv | 165 ++++++++++++++++
 tb/tb_seg_frame_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_decoder.sv
// Serial seven-segment display frame decoder: synchronizes a 64-bit serial display stream
// into clk, publishes each complete frame, and decodes the three score digits from it.
module seg_frame_decoder #(
  parameter int TIMEOUT    = 1024,
  parameter int FRAME_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SEGCLK,
  input  logic                  SEGCLR,
  input  logic                  SEGDT,
  input  logic                  SEGEN,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic [11:0]           score,
  output logic                  score_ok,
  output logic                  frame_err,
  output logic                  seg_en
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, state_nx;
  logic                    segclk_p0, segclk_p1, segclk_p2;
  logic                    segclr_p0, segclr_p1;
  logic                    segdt_p0, segdt_p1;
  logic                    segen_p0, segen_p1;
  logic                    clk_rise;
  logic [FRAME_BITS-1:0]   sr, sr_nx;
  logic [BW-1:0]           bit_cnt, bit_cnt_nx;
  logic [IW-1:0]           idle_cnt, idle_cnt_nx;
  logic                    err_nx;
  logic [4:0]              dig2, dig1, dig0;

  // Active-low segment pattern to {legal, value}; the dp bit is not part of the lookup.
  function automatic logic [4:0] decode_digit(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case (seg)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous synced SEGCLK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      segclk_p0 <= 1'b0; segclk_p1 <= 1'b0; segclk_p2 <= 1'b0;
      segclr_p0 <= 1'b0; segclr_p1 <= 1'b0;
      segdt_p0  <= 1'b0; segdt_p1  <= 1'b0;
      segen_p0  <= 1'b0; segen_p1  <= 1'b0;
    end else begin
      segclk_p0 <= SEGCLK; segclk_p1 <= segclk_p0; segclk_p2 <= segclk_p1;
      segclr_p0 <= SEGCLR; segclr_p1 <= segclr_p0;
      segdt_p0  <= SEGDT;  segdt_p1  <= segdt_p0;
      segen_p0  <= SEGEN;  segen_p1  <= segen_p0;
    end
  end

  assign clk_rise = segclk_p1 & ~segclk_p2;
  assign seg_en   = segen_p1;

  always_comb begin
    state_nx    = state;
    sr_nx       = sr;
    bit_cnt_nx  = bit_cnt;
    idle_cnt_nx = idle_cnt;
    err_nx      = 1'b0;
    if (!segclr_p1) begin
      err_nx      = (state == SHIFT) && (bit_cnt != '0);
      state_nx    = IDLE;
      sr_nx       = '0;
      bit_cnt_nx  = '0;
      idle_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt_nx  = '0;
          idle_cnt_nx = '0;
          if (clk_rise) begin
            sr_nx      = {sr[FRAME_BITS-2:0], segdt_p1};
            bit_cnt_nx = BW'(1);
            state_nx   = SHIFT;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            sr_nx       = {sr[FRAME_BITS-2:0], segdt_p1};
            bit_cnt_nx  = bit_cnt + BW'(1);
            idle_cnt_nx = '0;
            if (bit_cnt == LAST_BIT) state_nx = DONE;
          end else if (idle_cnt >= IDLE_MAX) begin
            // Stalled mid-frame: abandon it; the counter stops here rather than wrapping.
            state_nx    = IDLE;
            bit_cnt_nx  = '0;
            idle_cnt_nx = '0;
            err_nx      = 1'b1;
          end else begin
            idle_cnt_nx = idle_cnt + IW'(1);
          end
        end
        DONE: begin
          state_nx    = IDLE;
          bit_cnt_nx  = '0;
          idle_cnt_nx = '0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage p3: frame assembly state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      bit_cnt  <= bit_cnt_nx;
      idle_cnt <= idle_cnt_nx;
    end
  end

  assign dig2 = decode_digit(sr[22:16]);
  assign dig1 = decode_digit(sr[14:8]);
  assign dig0 = decode_digit(sr[6:0]);

  // Stage p4: published frame and score, updated only on frame completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame       <= '0;
      frame_valid <= 1'b0;
      score       <= '0;
      score_ok    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= (state == DONE);
      frame_err   <= err_nx;
      if (state == DONE) begin
        frame    <= sr;
        score    <= {dig2[3:0], dig1[3:0], dig0[3:0]};
        score_ok <= dig2[4] & dig1[4] & dig0[4];
      end
    end
  end

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: directed serial frames, clears, stalls and resets checked
// every cycle against an event-level receiver model, plus literal spot checks.
module tb_seg_frame_decoder;

  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        SEGCLK, SEGCLR, SEGDT, SEGEN;
  logic [63:0] frame;
  logic        frame_valid;
  logic [11:0] score;
  logic        score_ok, frame_err, seg_en;

  seg_frame_decoder #(.TIMEOUT(TIMEOUT), .FRAME_BITS(64)) dut (
    .clk(clk), .rst(rst), .SEGCLK(SEGCLK), .SEGCLR(SEGCLR), .SEGDT(SEGDT), .SEGEN(SEGEN),
    .frame(frame), .frame_valid(frame_valid), .score(score), .score_ok(score_ok),
    .frame_err(frame_err), .seg_en(seg_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Receiver model: bits taken on raw SEGCLK rises, results due a fixed number of cycles later.
  logic [63:0] m_bits = '0;
  int          m_nbits = 0;
  int          m_last = 0;
  logic [63:0] m_frame = '0;
  logic [11:0] m_score = '0;
  logic        m_ok = 1'b0;
  int          pend_cyc = -1;
  logic [63:0] pend_frame = '0;
  int          err_cyc = -1;
  logic        en_old = 1'b0, en_new = 1'b0;
  int          en_t = 0;
  int          err_seen = 0, valid_seen = 0;
  logic [7:0]  pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic void decode(input logic [63:0] f, output logic [11:0] s, output logic ok);
    s  = '0;
    ok = 1'b1;
    for (int d = 0; d < 3; d++) begin
      logic [7:0] b;
      logic       hit;
      b   = f[8*d +: 8];
      hit = 1'b0;
      for (int k = 0; k < 10; k++)
        if (b[6:0] == pat[k][6:0]) begin
          s[4*d +: 4] = 4'(k);
          hit = 1'b1;
        end
      if (!hit) ok = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_bit(input logic b);
    if (rst && SEGCLR) begin
      m_bits = {m_bits[62:0], b};
      m_nbits++;
      m_last = cyc;
      if (m_nbits == 64) begin
        pend_cyc   = cyc + 4;
        pend_frame = m_bits;
        m_nbits    = 0;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    SEGDT = b;
    tick(); tick();
    SEGCLK = 1'b1;
    model_bit(b);
    repeat (4) tick();
    SEGCLK = 1'b0;
    tick(); tick();
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 63; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic set_clr(input logic v);
    SEGCLR = v;
    if (!v && m_nbits > 0) err_cyc = cyc + 3;
    if (!v) m_nbits = 0;
  endtask

  task automatic set_en(input logic v);
    en_old = en_new;
    en_new = v;
    en_t   = cyc;
    SEGEN  = v;
  endtask

  task automatic assert_rst();
    rst = 1'b0;
    m_nbits = 0; m_frame = '0; m_score = '0; m_ok = 1'b0;
    pend_cyc = -1; err_cyc = -1;
    en_old = 1'b0; en_new = 1'b0;
  endtask

  task automatic release_rst();
    rst    = 1'b1;
    en_old = 1'b0;
    en_new = SEGEN;
    en_t   = cyc;
  endtask

  task automatic compare_cycle();
    logic exp_v, exp_e, exp_en;
    if (rst && m_nbits > 0 && cyc == m_last + 3 + TIMEOUT) begin
      err_cyc = cyc;
      m_nbits = 0;
    end
    exp_v = (pend_cyc == cyc);
    if (exp_v) begin
      m_frame = pend_frame;
      decode(pend_frame, m_score, m_ok);
    end
    exp_e  = (err_cyc == cyc);
    exp_en = !rst ? 1'b0 : (cyc >= en_t + 2) ? en_new : en_old;
    if (frame_valid === 1'b1) valid_seen++;
    if (frame_err === 1'b1) err_seen++;
    chk("frame_valid", 64'(frame_valid), 64'(exp_v));
    chk("frame_err", 64'(frame_err), 64'(exp_e));
    chk("frame", frame, m_frame);
    chk("score", 64'(score), 64'(m_score));
    chk("score_ok", 64'(score_ok), 64'(m_ok));
    chk("seg_en", 64'(seg_en), 64'(exp_en));
  endtask

  initial begin
    int e0, v0;
    rst = 1'b0; SEGCLK = 1'b0; SEGCLR = 1'b1; SEGDT = 1'b0; SEGEN = 1'b1;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (3) tick();
    chk("rst_frame", frame, 64'h0);
    chk("rst_score", 64'(score), 64'h0);
    chk("rst_seg_en", 64'(seg_en), 64'h0);
    release_rst();
    repeat (4) tick();

    send_frame(64'h92C6C08886C0F9A4);
    chk("lit_frame1", frame, 64'h92C6C08886C0F9A4);
    chk("lit_score1", 64'(score), 64'h012);
    chk("lit_ok1", 64'(score_ok), 64'h1);

    send_frame(64'h92C6C08886C0FFA4);
    chk("lit_score_bad", 64'(score), 64'h002);
    chk("lit_ok_bad", 64'(score_ok), 64'h0);

    // Clear while idle, with edges that must be ignored, and an enable toggle.
    e0 = err_seen;
    set_clr(1'b0);
    set_en(1'b0);
    repeat (3) send_bit(1'b1);
    set_clr(1'b1);
    set_en(1'b1);
    repeat (4) tick();
    chk("idle_clr_no_err", 64'(err_seen - e0), 64'd0);

    e0 = err_seen;
    for (int i = 0; i < 30; i++) send_bit(1'(i % 3));
    set_clr(1'b0);
    repeat (10) tick();
    set_clr(1'b1);
    repeat (4) tick();
    chk("clr_err_once", 64'(err_seen - e0), 64'd1);
    chk("clr_frame_held", frame, 64'h92C6C08886C0FFA4);
    send_frame(64'hC0F9A4B0999282F8);
    chk("lit_score_567", 64'(score), 64'h567);

    e0 = err_seen; v0 = valid_seen;
    for (int i = 0; i < 40; i++) send_bit(1'(i % 2));
    repeat (1100) tick();
    chk("timeout_err_once", 64'(err_seen - e0), 64'd1);
    chk("timeout_no_valid", 64'(valid_seen - v0), 64'd0);
    send_frame(64'h1111111111191000);
    chk("lit_score_dp", 64'(score), 64'h498);
    chk("lit_ok_dp", 64'(score_ok), 64'h1);

    e0 = err_seen;
    for (int i = 0; i < 50; i++) send_bit(1'(i % 5 == 0));
    assert_rst();
    repeat (5) tick();
    chk("midrst_frame", frame, 64'h0);
    chk("midrst_score", 64'(score), 64'h0);
    chk("midrst_ok", 64'(score_ok), 64'h0);
    release_rst();
    repeat (4) tick();
    send_frame(64'hDEADBEEF00C0C0C0);
    chk("midrst_no_err", 64'(err_seen - e0), 64'd0);
    chk("lit_frame_rst", frame, 64'hDEADBEEF00C0C0C0);
    chk("lit_score_000", 64'(score), 64'h000);

    v0 = valid_seen;
    send_frame(64'h0102030405060708);
    send_frame(64'hAAAA555500A4B099);
    repeat (4) tick();
    chk("b2b_valids", 64'(valid_seen - v0), 64'd2);
    chk("b2b_frame", frame, 64'hAAAA555500A4B099);
    chk("b2b_score", 64'(score), 64'h234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
